// File: rtl/hacd_wm_monitor.sv
// hacd_wm_monitor
//   Watches allocator activity for the HACD block. It keeps a running free-page
//   count, raises a level interrupt while that count is below the programmed
//   low watermark, and requests a compaction pass once enough page-free events
//   have accumulated since the previous compaction.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   ctrl_i              bit0 = enable, bit1 = interrupt enable
//   low_wm_i            low watermark in pages
//   cmpct_th_i          free-event threshold (0 or all-ones disables compaction)
//   total_pages_i       free count loaded when the block is enabled
//   alloc_i, free_i     one-page allocate / free pulses
//   cmpct_ack_i         compaction engine accepted the request
//   cmpct_done_i        compaction finished (single-cycle pulse)
//   cmpct_req_o         compaction request, held until acknowledged
//   low_wm_irq_o        low-watermark interrupt (level)
//   free_cnt_o          current free-page count
//   underflow_o         sticky: an allocation arrived with no free pages
//   busy_o              a compaction request/run/holdoff is in progress
module hacd_wm_monitor #(
    parameter int CNT_W       = 32,
    parameter int HOLDOFF_CYC = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      ctrl_i,
    input  logic [31:0]      low_wm_i,
    input  logic [31:0]      cmpct_th_i,
    input  logic [CNT_W-1:0] total_pages_i,
    input  logic             alloc_i,
    input  logic             free_i,
    input  logic             cmpct_ack_i,
    input  logic             cmpct_done_i,
    output logic             cmpct_req_o,
    output logic             low_wm_irq_o,
    output logic [CNT_W-1:0] free_cnt_o,
    output logic             underflow_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_MONITOR  = 3'd1,
        ST_REQ      = 3'd2,
        ST_BUSY     = 3'd3,
        ST_HOLDOFF  = 3'd4
    } state_t;

    // Holdoff counter runs from HOLDOFF_CYC-1 down to 0, so it only needs to
    // represent values below HOLDOFF_CYC.
    localparam int                HOLD_W    = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    free_cnt_q, free_cnt_d;
    logic [CNT_W-1:0]    frag_cnt_q, frag_cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                underflow_q, underflow_d;
    logic                irq_q, irq_d;

    logic                enable;
    logic                irq_en;
    logic                th_valid;
    logic [CNT_W-1:0]    th_c;
    logic [CNT_W-1:0]    low_wm_c;
    logic                unused_ctrl_bits;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] floor_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - CNT_W'(1);
    endfunction

    assign enable           = ctrl_i[0];
    assign irq_en           = ctrl_i[1];
    assign unused_ctrl_bits = ^ctrl_i[31:2];
    assign th_c             = CNT_W'(cmpct_th_i);
    assign low_wm_c         = CNT_W'(low_wm_i);
    assign th_valid         = (cmpct_th_i != '0) && (cmpct_th_i != '1);

    // State and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_DISABLED;
            free_cnt_q  <= '0;
            frag_cnt_q  <= '0;
            hold_q      <= '0;
            underflow_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            free_cnt_q  <= free_cnt_d;
            frag_cnt_q  <= frag_cnt_d;
            hold_q      <= hold_d;
            underflow_q <= underflow_d;
            irq_q       <= irq_d;
        end
    end

    // Next-state logic; losing the enable bit overrides every transition.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: state_d = ST_MONITOR;
                ST_MONITOR:  if (th_valid && (frag_cnt_q >= th_c)) state_d = ST_REQ;
                ST_REQ:      if (cmpct_ack_i)     state_d = ST_BUSY;
                ST_BUSY:     if (cmpct_done_i)    state_d = ST_HOLDOFF;
                ST_HOLDOFF:  if (hold_q == '0)    state_d = ST_MONITOR;
                default:     state_d = ST_DISABLED;
            endcase
        end
    end

    // Counter datapath
    always_comb begin
        free_cnt_d  = free_cnt_q;
        frag_cnt_d  = frag_cnt_q;
        hold_d      = hold_q;
        underflow_d = underflow_q;

        if (state_q == ST_DISABLED) begin
            if (enable) begin
                free_cnt_d = total_pages_i;
                frag_cnt_d = '0;
            end
        end else begin
            // Simultaneous alloc+free cancel out, so no underflow at zero.
            if (alloc_i && !free_i) begin
                free_cnt_d = floor_dec(free_cnt_q);
                if (free_cnt_q == '0) underflow_d = 1'b1;
            end else if (free_i && !alloc_i) begin
                free_cnt_d = sat_inc(free_cnt_q);
            end

            if (free_i) frag_cnt_d = sat_inc(frag_cnt_q);

            // A free landing on the done cycle belongs to the next epoch.
            if (state_q == ST_BUSY && cmpct_done_i) begin
                frag_cnt_d = CNT_W'(free_i);
                hold_d     = HOLD_LOAD;
            end else if (state_q == ST_HOLDOFF && hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end

        // Compares against the registered count, so the interrupt trails
        // the count change by one cycle.
        irq_d = enable && irq_en && (free_cnt_q < low_wm_c);
    end

    // Outputs decoded from state
    always_comb begin
        cmpct_req_o = (state_q == ST_REQ);
        busy_o      = (state_q == ST_REQ) || (state_q == ST_BUSY) || (state_q == ST_HOLDOFF);
    end

    assign free_cnt_o   = free_cnt_q;
    assign underflow_o  = underflow_q;
    assign low_wm_irq_o = irq_q;

endmodule

// File: tb/tb_hacd_wm_monitor.sv
module tb_hacd_wm_monitor;

    localparam int     CNT_W       = 32;
    localparam int     HOLDOFF_CYC = 64;
    localparam longint MAXV        = 64'h0000_0000_FFFF_FFFF;

    localparam int S_DIS = 0, S_MON = 1, S_REQ = 2, S_BUSY = 3, S_HOLD = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [31:0]      ctrl_i, low_wm_i, cmpct_th_i;
    logic [CNT_W-1:0] total_pages_i;
    logic             alloc_i, free_i, cmpct_ack_i, cmpct_done_i;
    logic             cmpct_req_o, low_wm_irq_o, underflow_o, busy_o;
    logic [CNT_W-1:0] free_cnt_o;

    always #5 clk_i = ~clk_i;

    hacd_wm_monitor #(.CNT_W(CNT_W), .HOLDOFF_CYC(HOLDOFF_CYC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ctrl_i        (ctrl_i),
        .low_wm_i      (low_wm_i),
        .cmpct_th_i    (cmpct_th_i),
        .total_pages_i (total_pages_i),
        .alloc_i       (alloc_i),
        .free_i        (free_i),
        .cmpct_ack_i   (cmpct_ack_i),
        .cmpct_done_i  (cmpct_done_i),
        .cmpct_req_o   (cmpct_req_o),
        .low_wm_irq_o  (low_wm_irq_o),
        .free_cnt_o    (free_cnt_o),
        .underflow_o   (underflow_o),
        .busy_o        (busy_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: mode plus free/fragment counts as plain integers.
    int     m_mode;
    longint m_free, m_frag;
    bit     m_uf, m_irq;
    int     m_hold_elapsed;

    task automatic model_step();
        longint nf, ng, th, lw;
        int     nm, nh;
        bit     nuf, en;
        if (rst_i) begin
            m_mode = S_DIS; m_free = 0; m_frag = 0; m_uf = 0; m_irq = 0; m_hold_elapsed = 0;
            return;
        end
        en  = ctrl_i[0];
        th  = {32'b0, cmpct_th_i};
        lw  = {32'b0, low_wm_i};
        nf  = m_free; ng = m_frag; nm = m_mode; nuf = m_uf; nh = m_hold_elapsed;
        if (m_mode == S_DIS) begin
            if (en) begin
                nf = {32'b0, total_pages_i};
                ng = 0;
                nm = S_MON;
            end
        end else begin
            if (alloc_i && !free_i) begin
                if (m_free == 0) nuf = 1;
                else             nf  = m_free - 1;
            end
            if (free_i && !alloc_i) nf = (m_free == MAXV) ? MAXV : m_free + 1;
            if (free_i && m_frag < MAXV) ng = m_frag + 1;
            case (m_mode)
                S_MON:  if (th != 0 && th != MAXV && m_frag >= th) nm = S_REQ;
                S_REQ:  if (cmpct_ack_i) nm = S_BUSY;
                S_BUSY: if (cmpct_done_i) begin ng = free_i; nm = S_HOLD; nh = 0; end
                S_HOLD: begin
                    nh = m_hold_elapsed + 1;
                    if (nh >= HOLDOFF_CYC) nm = S_MON;
                end
                default: ;
            endcase
            if (!en) nm = S_DIS;
        end
        m_irq  = en && ctrl_i[1] && (m_free < lw);
        m_free = nf; m_frag = ng; m_mode = nm; m_uf = nuf; m_hold_elapsed = nh;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        check_val("req",   cmpct_req_o,  m_mode == S_REQ);
        check_val("busy",  busy_o,       m_mode == S_REQ || m_mode == S_BUSY || m_mode == S_HOLD);
        check_val("free",  free_cnt_o,   m_free);
        check_val("uf",    underflow_o,  m_uf);
        check_val("irq",   low_wm_irq_o, m_irq);
    endtask

    task automatic wait_req(input string tag);
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (cmpct_req_o) seen = 1;
        end
        check_val(tag, seen, 1);
    endtask

    initial begin
        int     cnt;
        bit     seen;
        longint exp_free;

        m_mode = S_DIS; m_free = 0; m_frag = 0; m_uf = 0; m_irq = 0; m_hold_elapsed = 0;
        rst_i = 1; ctrl_i = 0; low_wm_i = 0; cmpct_th_i = '1; total_pages_i = 0;
        alloc_i = 0; free_i = 0; cmpct_ack_i = 0; cmpct_done_i = 0;
        tick(); tick();
        check_val("rst_free", free_cnt_o, 0);
        check_val("rst_req",  cmpct_req_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_irq",  low_wm_irq_o, 0);
        check_val("rst_uf",   underflow_o, 0);
        rst_i = 0;

        // Watermark interrupt rise and fall
        total_pages_i = 100; ctrl_i = 3; low_wm_i = 98;
        tick(); check_val("en_load", free_cnt_o, 100);
        alloc_i = 1;
        tick(); check_val("alloc1", free_cnt_o, 99);
        tick(); check_val("alloc2", free_cnt_o, 98);
        tick(); check_val("alloc3", free_cnt_o, 97);
        check_val("irq_early", low_wm_irq_o, 0);
        alloc_i = 0;
        tick(); check_val("irq_rise", low_wm_irq_o, 1);
        free_i = 1;
        tick(); check_val("free_back", free_cnt_o, 98);
        check_val("irq_hold", low_wm_irq_o, 1);
        free_i = 0;
        tick(); check_val("irq_clear", low_wm_irq_o, 0);

        // Compaction handshake with delayed ack and holdoff
        ctrl_i = 0; tick();
        ctrl_i = 3; cmpct_th_i = 4; tick();
        check_val("reload100", free_cnt_o, 100);
        free_i = 1;
        for (int i = 0; i < 4; i++) tick();
        free_i = 0;
        check_val("req_not_yet", cmpct_req_o, 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cmpct_req_o) cnt++;
        end
        check_val("req_held5", cnt, 5);
        cmpct_ack_i = 1; tick(); cmpct_ack_i = 0;
        check_val("req_drop_ack", cmpct_req_o, 0);
        check_val("busy_run", busy_o, 1);
        tick(); tick(); tick();
        cmpct_done_i = 1; tick(); cmpct_done_i = 0;
        check_val("busy_done", busy_o, 1);
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!busy_o) break;
            cnt++;
        end
        check_val("holdoff_len", cnt, HOLDOFF_CYC);
        free_i = 1;
        for (int i = 0; i < 3; i++) tick();
        free_i = 0;
        tick(); tick();
        check_val("frag_cleared", cmpct_req_o, 0);

        // Threshold all-ones: compaction disabled
        cmpct_th_i = '1;
        exp_free = m_free + 1000;
        seen = 0;
        free_i = 1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (cmpct_req_o) seen = 1;
        end
        free_i = 0;
        tick();
        check_val("no_req_allones", seen, 0);
        check_val("free_plus1000", free_cnt_o, exp_free);

        // Underflow behaviour at zero
        rst_i = 1; tick(); rst_i = 0;
        total_pages_i = 0; ctrl_i = 1;
        tick();
        alloc_i = 1; free_i = 1;
        tick(); check_val("both_at0_free", free_cnt_o, 0);
        check_val("both_at0_uf", underflow_o, 0);
        free_i = 0;
        tick(); check_val("uf_free", free_cnt_o, 0);
        check_val("uf_set", underflow_o, 1);
        alloc_i = 0; free_i = 1;
        tick(); free_i = 0;
        check_val("uf_sticky", underflow_o, 1);

        // Disable while requesting
        ctrl_i = 0; tick();
        ctrl_i = 1; total_pages_i = 500; cmpct_th_i = 2; tick();
        free_i = 1; tick(); tick(); free_i = 0;
        wait_req("req_seen_dis");
        ctrl_i = 0;
        tick();
        check_val("dis_req_drop", cmpct_req_o, 0);
        check_val("dis_busy", busy_o, 0);
        alloc_i = 1; tick(); tick(); alloc_i = 0;
        check_val("dis_alloc_ignored", free_cnt_o, 502);
        check_val("dis_uf_kept", underflow_o, 1);
        total_pages_i = 777; ctrl_i = 1;
        tick(); check_val("reenable_reload", free_cnt_o, 777);

        // Reset during BUSY
        free_i = 1; tick(); tick(); free_i = 0;
        wait_req("req_seen_rst");
        cmpct_ack_i = 1; tick(); cmpct_ack_i = 0;
        check_val("in_busy", busy_o, 1);
        rst_i = 1; ctrl_i = 0; tick(); rst_i = 0;
        check_val("rstb_req",  cmpct_req_o, 0);
        check_val("rstb_busy", busy_o, 0);
        check_val("rstb_free", free_cnt_o, 0);
        check_val("rstb_uf",   underflow_o, 0);
        cmpct_done_i = 1; tick(); cmpct_done_i = 0; tick();
        check_val("done_ignored", busy_o, 0);

        // Randomised traffic against the model
        ctrl_i = 3; cmpct_th_i = 5; low_wm_i = 4; total_pages_i = 6;
        for (int i = 0; i < 6000; i++) begin
            int alloc_bias;
            rst_i = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 199) == 0)
                ctrl_i = ($urandom_range(0, 9) < 8) ? (32'h1 | ($urandom & 32'hFFFF_FFFE)) : ($urandom & 32'hFFFF_FFFE);
            if ($urandom_range(0, 149) == 0) begin
                case ($urandom_range(0, 3))
                    0: cmpct_th_i = 0;
                    1: cmpct_th_i = '1;
                    default: cmpct_th_i = $urandom_range(1, 12);
                endcase
            end
            if ($urandom_range(0, 99) == 0) low_wm_i = $urandom_range(0, 12);
            if ($urandom_range(0, 199) == 0)
                total_pages_i = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 8) : 32'hFFFF_FFF8 + $urandom_range(0, 7);
            alloc_bias   = (i / 500) % 2 == 0 ? 3 : 1;
            alloc_i      = ($urandom_range(0, 3) < alloc_bias);
            free_i       = ($urandom_range(0, 3) >= alloc_bias);
            cmpct_ack_i  = ($urandom_range(0, 3) == 0);
            cmpct_done_i = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
